// File: rtl/pwm_duty_sched.sv
// pwm_duty_sched: push-button duty editor and phase-staggered auto sweep.
// Optional PWM_SCHED_GAMMA_EN squares CFG_DUTY on its way to the PWM bank.
module pwm_duty_sched #(
    parameter int CH_NUM   = 10,
    parameter int DUTY_W   = 8,
    parameter int DEB_CYC  = 1000000,
    parameter int RAMP_DIV = 195312,
    parameter int STEP     = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [3:0]        PUSH,
    input  logic              AUTO,
    output logic              CFG_VALID,
    input  logic              CFG_READY,
    output logic [3:0]        CFG_CH,
    output logic [DUTY_W-1:0] CFG_DUTY,
    output logic [3:0]        CUR_CH,
    output logic [DUTY_W-1:0] CUR_DUTY,
    output logic              BUSY
);
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int DEB_W  = $clog2(DEB_CYC + 1);
    localparam int TICK_W = $clog2(RAMP_DIV + 1);

    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0]   FULL_X    = {1'b0, {DUTY_W{1'b1}}};
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CH_NUM - 1);

    typedef enum logic [1:0] {IDLE, WRITE, SCAN} state_t;

    logic unused_push;
    assign unused_push = PUSH[3];

    // Synchronizers; push bits idle high so they reset to the released level.
    logic [2:0] push_s1_q, push_s2_q;
    logic       auto_s1_q, auto_s2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            push_s1_q <= '1;
            push_s2_q <= '1;
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
        end else begin
            push_s1_q <= PUSH[2:0];
            push_s2_q <= push_s1_q;
            auto_s1_q <= AUTO;
            auto_s2_q <= auto_s1_q;
        end
    end

    logic [2:0]       deb_q, deb_d, press;
    logic [DEB_W-1:0] cnt_q [3];
    logic [DEB_W-1:0] cnt_d [3];

    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (push_s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = push_s2_q[i];
                    press[i] = deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_q <= '1;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              tick;

    always_comb begin
        tick_d = '0;
        tick   = 1'b0;
        if (auto_s2_q) begin
            if (tick_q == TICK_LAST) tick = 1'b1;
            else tick_d = tick_q + TICK_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tick_q <= '0;
        else tick_q <= tick_d;
    end

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q [CH_NUM];
    logic [DUTY_W-1:0] duty_d [CH_NUM];
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DUTY_W-1:0] lin_q, lin_d;
    logic [DUTY_W-1:0] phase_q, phase_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [DUTY_W-1:0] last_duty_q, last_duty_d;

    logic [DUTY_W-1:0] cur_lin, new_lin;
    logic [DUTY_W:0]   inc_x, dec_x, inc_sat, dec_sat;
    logic              manual, acc;
    logic              do_inc, do_dec, do_next, do_tick;

    always_comb begin
        cur_lin = duty_q[sel_q];
        inc_x   = {1'b0, cur_lin} + STEP_X;
        dec_x   = {1'b0, cur_lin} - STEP_X;
        inc_sat = (inc_x > FULL_X) ? FULL_X : inc_x;
        dec_sat = dec_x[DUTY_W] ? '0 : dec_x;
        manual  = (state_q == IDLE) && !auto_s2_q;
        acc     = (state_q != IDLE) && CFG_READY;
        do_inc  = manual && press[1]
                  && (inc_sat[DUTY_W-1:0] != cur_lin);
        do_dec  = manual && !press[1] && press[0]
                  && (dec_sat[DUTY_W-1:0] != cur_lin);
        do_next = manual && press[2] && !press[1] && !press[0];
        do_tick = tick && (state_q == IDLE);
        new_lin = do_inc ? inc_sat[DUTY_W-1:0] : dec_sat[DUTY_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (do_tick) state_d = SCAN;
                else if (do_inc || do_dec) state_d = WRITE;
            end
            WRITE: begin
                if (CFG_READY) state_d = IDLE;
            end
            SCAN: begin
                if (CFG_READY && ch_q == CH_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        duty_d      = duty_q;
        sel_d       = sel_q;
        ch_d        = ch_q;
        lin_d       = lin_q;
        phase_d     = phase_q;
        last_ch_d   = last_ch_q;
        last_duty_d = last_duty_q;
        unique case (1'b1)
            do_tick: begin
                phase_d = phase_q + STEP_D;
                ch_d    = '0;
                lin_d   = phase_q + STEP_D;
            end
            do_inc, do_dec: begin
                duty_d[sel_q] = new_lin;
                ch_d          = sel_q;
                lin_d         = new_lin;
            end
            do_next: begin
                sel_d = (sel_q == CH_LAST) ? '0 : sel_q + CH_W'(1);
            end
            default: ;
        endcase
        // Scan writes land in the array only once the bank accepts them.
        if (acc) begin
            last_ch_d   = ch_q;
            last_duty_d = lin_q;
            if (state_q == SCAN) begin
                duty_d[ch_q] = lin_q;
                if (ch_q != CH_LAST) begin
                    ch_d  = ch_q + CH_W'(1);
                    lin_d = lin_q + STEP_D;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            for (int i = 0; i < CH_NUM; i++) duty_q[i] <= '0;
            sel_q       <= '0;
            ch_q        <= '0;
            lin_q       <= '0;
            phase_q     <= '0;
            last_ch_q   <= '0;
            last_duty_q <= '0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < CH_NUM; i++) duty_q[i] <= duty_d[i];
            sel_q       <= sel_d;
            ch_q        <= ch_d;
            lin_q       <= lin_d;
            phase_q     <= phase_d;
            last_ch_q   <= last_ch_d;
            last_duty_q <= last_duty_d;
        end
    end

`ifdef PWM_SCHED_GAMMA_EN
    function automatic logic [DUTY_W-1:0] gamma(input logic [DUTY_W-1:0] d);
        logic [2*DUTY_W-1:0] sq;
        sq = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d};
        return sq[2*DUTY_W-1:DUTY_W];
    endfunction

    logic [DUTY_W-1:0] gam_q, gam_d;

    always_comb gam_d = gamma(lin_d);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) gam_q <= '0;
        else gam_q <= gam_d;
    end

    assign CFG_DUTY = gam_q;
`else
    assign CFG_DUTY = lin_q;
`endif

    always_comb begin
        CFG_VALID = (state_q != IDLE);
        BUSY      = (state_q != IDLE);
        CFG_CH    = 4'(ch_q);
        if (auto_s2_q) begin
            CUR_CH   = 4'(last_ch_q);
            CUR_DUTY = last_duty_q;
        end else begin
            CUR_CH   = 4'(sel_q);
            CUR_DUTY = cur_lin;
        end
    end
endmodule

// File: tb/tb_pwm_duty_sched.sv
// tb_pwm_duty_sched: directed stimulus with a queue-based write scoreboard.
// Builds with or without PWM_SCHED_GAMMA_EN.
module tb_pwm_duty_sched;
    localparam int CH_NUM   = 10;
    localparam int DUTY_W   = 8;
    localparam int DEB_CYC  = 4;
    localparam int RAMP_DIV = 16;
    localparam int STEP     = 16;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [3:0]        PUSH;
    logic              AUTO;
    logic              CFG_VALID;
    logic              CFG_READY;
    logic [3:0]        CFG_CH;
    logic [DUTY_W-1:0] CFG_DUTY;
    logic [3:0]        CUR_CH;
    logic [DUTY_W-1:0] CUR_DUTY;
    logic              BUSY;

    pwm_duty_sched #(
        .CH_NUM(CH_NUM), .DUTY_W(DUTY_W), .DEB_CYC(DEB_CYC),
        .RAMP_DIV(RAMP_DIV), .STEP(STEP)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .AUTO(AUTO),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_CH(CFG_CH), .CFG_DUTY(CFG_DUTY),
        .CUR_CH(CUR_CH), .CUR_DUTY(CUR_DUTY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] ch;
        logic [7:0] duty;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;

    function automatic logic [7:0] exp_cfg(input int d);
`ifdef PWM_SCHED_GAMMA_EN
        return 8'((d * d) >> 8);
`else
        return 8'(d);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_wr(input int ch, input int d);
        wr_t w;
        w.ch   = 4'(ch);
        w.duty = exp_cfg(d);
        exp_q.push_back(w);
    endtask

    // Scoreboard monitor: every accepted write must match the queue head.
    always @(negedge CLK) begin
        if (RST_N && CFG_VALID && CFG_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: ch=%0d duty=%0d expected none",
                         CFG_CH, CFG_DUTY);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_ch", int'(CFG_CH), int'(mon_e.ch));
                check("write_duty", int'(CFG_DUTY), int'(mon_e.duty));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [2:0] m);
        PUSH = {1'b1, ~m};
        step(DEB_CYC + 4);
        PUSH = 4'hF;
        step(DEB_CYC + 4);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(CFG_VALID), 0);
        check({tag, "_cfg_ch"}, int'(CFG_CH), 0);
        check({tag, "_cfg_duty"}, int'(CFG_DUTY), 0);
        check({tag, "_cur_ch"}, int'(CUR_CH), 0);
        check({tag, "_cur_duty"}, int'(CUR_DUTY), 0);
        check({tag, "_busy"}, int'(BUSY), 0);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!CFG_VALID && n < bound) begin
            step(1);
            n++;
        end
        check({tag, "_valid_seen"}, int'(CFG_VALID), 1);
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (BUSY && n < 60) begin
            step(1);
            n++;
        end
        check({tag, "_busy_low"}, int'(BUSY), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_N     = 1'b0;
        PUSH      = 4'hF;
        AUTO      = 1'b0;
        CFG_READY = 1'b1;
        step(2);
        check_zero("reset");
        RST_N = 1'b1;
        step(2);

        // Reset while a write is stalled
        CFG_READY = 1'b0;
        PUSH      = 4'b1101;
        wait_valid("stall", 30);
        RST_N = 1'b0;
        #1;
        check_zero("midreset");
        PUSH = 4'hF;
        step(3);
        RST_N     = 1'b1;
        CFG_READY = 1'b1;
        step(3);

        // Increment up to saturation on channel 0
        expect_wr(0, 16);
        press(3'b010);
        for (int k = 2; k <= 15; k++) begin
            expect_wr(0, 16 * k);
            press(3'b010);
        end
        expect_wr(0, 255);
        press(3'b010);
        check("sat_cur_duty", int'(CUR_DUTY), 255);
        press(3'b010);
        check("sat_hold", int'(CUR_DUTY), 255);

        // Short glitch is filtered
        PUSH = 4'b1101;
        step(2);
        PUSH = 4'hF;
        step(12);
        check("glitch_cur_duty", int'(CUR_DUTY), 255);
        check("glitch_no_write", exp_q.size(), 0);

        // Channel wrap, dec floor, inc beats dec
        press(3'b100);
        check("next_ch1", int'(CUR_CH), 1);
        for (int k = 0; k < 9; k++) press(3'b100);
        check("wrap_ch0", int'(CUR_CH), 0);
        check("wrap_duty", int'(CUR_DUTY), 255);
        press(3'b100);
        press(3'b001);
        check("dec_floor", int'(CUR_DUTY), 0);
        expect_wr(1, 16);
        press(3'b011);
        check("prio_duty", int'(CUR_DUTY), 16);

        // Backpressure with a dropped dec
        CFG_READY = 1'b0;
        expect_wr(1, 32);
        PUSH = 4'b1101;
        wait_valid("bp", 30);
        PUSH = 4'b1110;
        for (int k = 0; k < 14; k++) begin
            if (k == 12) PUSH = 4'hF;
            check("bp_valid", int'(CFG_VALID), 1);
            check("bp_ch", int'(CFG_CH), 1);
            check("bp_duty", int'(CFG_DUTY), int'(exp_cfg(32)));
            check("bp_busy", int'(BUSY), 1);
            step(1);
        end
        CFG_READY = 1'b1;
        step(12);
        check("bp_done", int'(BUSY), 0);
        check("bp_cur_duty", int'(CUR_DUTY), 32);

        // Auto sweep, then drop AUTO mid-scan
        for (int k = 0; k < CH_NUM; k++) expect_wr(k, 16 + 16 * k);
        AUTO = 1'b1;
        wait_valid("scan1", 40);
        wait_idle("scan1", n);
        check("scan1_cycles", n, CH_NUM);
        check("scan1_cur_ch", int'(CUR_CH), 9);
        check("scan1_cur_duty", int'(CUR_DUTY), 160);
        for (int k = 0; k < CH_NUM; k++) expect_wr(k, 32 + 16 * k);
        wait_valid("scan2", 40);
        n = 0;
        while (!(CFG_VALID && CFG_CH == 4'd3) && n < 40) begin
            step(1);
            n++;
        end
        AUTO = 1'b0;
        wait_idle("scan2", n);
        step(40);
        check("manual_cur_ch", int'(CUR_CH), 1);
        check("manual_cur_duty", int'(CUR_DUTY), 48);
        check("auto_off_idle", int'(BUSY), 0);
        check("scan_drained", exp_q.size(), 0);

        // Gamma path (linear without the macro)
        RST_N = 1'b0;
        step(2);
        RST_N = 1'b1;
        step(2);
        for (int k = 1; k <= 8; k++) begin
            expect_wr(0, 16 * k);
            press(3'b010);
        end
        check("gamma_cur_duty", int'(CUR_DUTY), 128);

        step(4);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
